// File: rtl/seg7_pkg.sv
// Shared types, segment codes and helpers for the four-digit decimal display path.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int VALUE_W    = 13;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } conv_state_e;

  // Active-low, bit order gfedcba.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_encode = SEG_0;
      4'd1:    seg_encode = SEG_1;
      4'd2:    seg_encode = SEG_2;
      4'd3:    seg_encode = SEG_3;
      4'd4:    seg_encode = SEG_4;
      4'd5:    seg_encode = SEG_5;
      4'd6:    seg_encode = SEG_6;
      4'd7:    seg_encode = SEG_7;
      4'd8:    seg_encode = SEG_8;
      4'd9:    seg_encode = SEG_9;
      default: seg_encode = SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction: any nibble of 5 or more would overflow past 9 when doubled.
  function automatic logic [BCD_W-1:0] add3_adjust(input logic [BCD_W-1:0] bcd);
    logic [3:0] nib;
    add3_adjust = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib = bcd[4*i +: 4];
      add3_adjust[4*i +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    end
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Free-running sequential binary-to-BCD converter, one result every 15 clocks.
//   state    | meaning
//   ST_IDLE  | capture bin, clear accumulator
//   ST_SHIFT | 13 add-3/shift iterations
//   ST_LOAD  | accumulator final, bcd_valid pulses
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] bin,
  output logic [BCD_W-1:0]   bcd,
  output logic               bcd_valid
);

  localparam logic [3:0] LAST_ITER = 4'(VALUE_W - 1);

  conv_state_e                state;
  logic [VALUE_W-1:0]         bin_sh;
  logic [BCD_W-1:0]           acc;
  logic [3:0]                 iter;
  logic [BCD_W+VALUE_W-1:0]   shifted;

  always_comb shifted = {add3_adjust(acc), bin_sh} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      bin_sh <= '0;
      acc    <= '0;
      iter   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bin_sh <= bin;
          acc    <= '0;
          iter   <= '0;
          state  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          {acc, bin_sh} <= shifted;
          iter          <= iter + 4'd1;
          if (iter == LAST_ITER) state <= ST_LOAD;
        end
        ST_LOAD: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bcd       = acc;
  assign bcd_valid = (state == ST_LOAD);

endmodule

// File: rtl/seg7_bcd_scanner.sv
// Shows a 13-bit value in decimal on a four-digit common-anode display,
// scanning one digit per REFRESH_DIV clocks with optional leading-zero blanking.
module seg7_bcd_scanner
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value,
  output logic [6:0]         seg,
  output logic [0:3]         anode
);

  localparam int              DIV_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [BCD_W-1:0] conv_bcd;
  logic             conv_valid;
  logic [BCD_W-1:0] bcd_reg;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [1:0]       digit_idx;
  logic [1:0]       next_idx;
  logic [3:0]       nib;
  logic             blank_slot;
  logic             zero_th;
  logic             zero_th_hu;
  logic             zero_th_hu_te;
  logic [6:0]       seg_next;
  logic [0:3]       anode_next;

  bin2bcd_seq u_conv (
    .clk       (clk),
    .rst       (rst),
    .bin       (value),
    .bcd       (conv_bcd),
    .bcd_valid (conv_valid)
  );

  assign tick = (div_cnt == DIV_LAST);

  // Outputs are precomputed for the slot the next tick will select.
  always_comb begin
    next_idx      = digit_idx + 2'd1;
    zero_th       = (bcd_reg[15:12] == 4'd0);
    zero_th_hu    = zero_th && (bcd_reg[11:8] == 4'd0);
    zero_th_hu_te = zero_th_hu && (bcd_reg[7:4] == 4'd0);
    nib           = 4'd0;
    blank_slot    = 1'b0;
    anode_next    = 4'b1111;
    case (next_idx)
      2'd0: begin
        nib        = bcd_reg[3:0];
        anode_next = 4'b1110;
      end
      2'd1: begin
        nib        = bcd_reg[7:4];
        blank_slot = zero_th_hu_te;
        anode_next = 4'b1101;
      end
      2'd2: begin
        nib        = bcd_reg[11:8];
        blank_slot = zero_th_hu;
        anode_next = 4'b1011;
      end
      default: begin
        nib        = bcd_reg[15:12];
        blank_slot = zero_th;
        anode_next = 4'b0111;
      end
    endcase
    seg_next = (BLANK_LEADING && blank_slot) ? SEG_BLANK : seg_encode(nib);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_reg   <= '0;
      div_cnt   <= '0;
      digit_idx <= '0;
      anode     <= 4'b1111;
      seg       <= SEG_BLANK;
    end else begin
      if (conv_valid) bcd_reg <= conv_bcd;
      if (tick) begin
        div_cnt   <= '0;
        digit_idx <= next_idx;
        anode     <= anode_next;
        seg       <= seg_next;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg7_bcd_scanner.sv
// Self-checking bench for seg7_bcd_scanner: a cycle model feeds a scoreboard of expected
// display slots and conversion results; each test task compares inline.
module tb_seg7_bcd_scanner;

  localparam int         REFRESH_DIV = 4;
  localparam logic [6:0] BL          = 7'b1111111;
  localparam logic [6:0] CODES [10]  = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                         7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                         7'b0000000, 7'b0010000};

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] value;
  logic [6:0]  seg, seg_nb;
  logic [0:3]  anode, anode_nb;

  seg7_bcd_scanner #(.REFRESH_DIV(REFRESH_DIV), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .rst(rst), .value(value), .seg(seg), .anode(anode));

  seg7_bcd_scanner #(.REFRESH_DIV(REFRESH_DIV), .BLANK_LEADING(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .value(value), .seg(seg_nb), .anode(anode_nb));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:3] anode;
    logic [6:0] seg;
    logic [6:0] seg_nb;
  } disp_t;

  disp_t disp_q[$];
  int    conv_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  int         m_div, m_phase, m_cap, m_disp;
  logic [1:0] m_idx;

  function automatic logic [6:0] exp_seg(int v, int idx, bit bl);
    int p;
    p = (idx == 0) ? 1 : (idx == 1) ? 10 : (idx == 2) ? 100 : 1000;
    if (bl && idx != 0 && v < p) return BL;
    return CODES[(v / p) % 10];
  endfunction

  function automatic logic [0:3] exp_anode(logic [1:0] idx);
    case (idx)
      2'd0:    return 4'b1110;
      2'd1:    return 4'b1101;
      2'd2:    return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_div = 0; m_phase = 0; m_cap = 0; m_disp = 0; m_idx = 2'd0;
    disp_q.delete();
    conv_q.delete();
  endtask

  // Advance one clock, sample 1 ns later, and step the reference model.
  task automatic step(output bit tick);
    disp_t e;
    @(posedge clk);
    #1;
    tick = (m_div == REFRESH_DIV - 1);
    if (tick) begin
      m_idx    = m_idx + 2'd1;
      e.anode  = exp_anode(m_idx);
      e.seg    = exp_seg(m_disp, int'(m_idx), 1'b1);
      e.seg_nb = exp_seg(m_disp, int'(m_idx), 1'b0);
      disp_q.push_back(e);
      m_div = 0;
    end else begin
      m_div++;
    end
    if (m_phase == 0)  m_cap = int'(value);
    if (m_phase == 13) conv_q.push_back(m_cap);
    if (m_phase == 14) m_disp = m_cap;
    m_phase = (m_phase == 14) ? 0 : m_phase + 1;
  endtask

  task automatic apply_reset(input logic [12:0] v);
    @(negedge clk);
    rst   = 1'b1;
    value = v;
    @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (anode !== 4'b1111) begin miscompares++; $display("FAIL reset_anode: got %b want 1111", anode); end
    vectors++;
    if (seg !== BL) begin miscompares++; $display("FAIL reset_seg: got %b want %b", seg, BL); end
    vectors++;
    if (seg_nb !== BL) begin miscompares++; $display("FAIL reset_seg_nb: got %b want %b", seg_nb, BL); end
    vectors++;
    if (dut.bcd_reg !== 16'h0000) begin miscompares++; $display("FAIL reset_bcd_reg: got %h want 0000", dut.bcd_reg); end
  endtask

  task automatic test_conversion();
    bit tick; disp_t e; int ev; logic exp_v; logic [6:0] hand;
    apply_reset(13'd1234);
    for (int c = 1; c <= 32; c++) begin
      step(tick);
      exp_v = (c == 14 || c == 29);
      vectors++;
      if (dut.u_conv.bcd_valid !== exp_v) begin
        miscompares++; $display("FAIL conv_valid_c%0d: got %b want %b", c, dut.u_conv.bcd_valid, exp_v);
      end
      if (dut.u_conv.bcd_valid === 1'b1 && conv_q.size() > 0) begin
        ev = conv_q.pop_front();
        vectors++;
        if (dut.u_conv.bcd !== to_bcd(ev)) begin
          miscompares++; $display("FAIL conv_bcd_c%0d: got %h want %h", c, dut.u_conv.bcd, to_bcd(ev));
        end
      end
      if (c == 15) begin
        vectors++;
        if (dut.bcd_reg !== 16'h1234) begin miscompares++; $display("FAIL conv_bcd_reg: got %h want 1234", dut.bcd_reg); end
      end
      if (tick) begin
        e = disp_q.pop_front();
        vectors++;
        if (anode !== e.anode || seg !== e.seg || seg_nb !== e.seg_nb) begin
          miscompares++;
          $display("FAIL conv_slot_c%0d: got %b/%b/%b want %b/%b/%b", c, anode, seg, seg_nb, e.anode, e.seg, e.seg_nb);
        end
      end
      hand = (c == 16) ? 7'b0011001 : (c == 20) ? 7'b0110000 : (c == 24) ? 7'b0100100 : 7'b1111001;
      if (c == 16 || c == 20 || c == 24 || c == 28) begin
        vectors++;
        if (seg !== hand) begin miscompares++; $display("FAIL conv_digit_c%0d: got %b want %b", c, seg, hand); end
      end
    end
  endtask

  task automatic test_max_value();
    bit tick; disp_t e; int ev; logic [6:0] th_seg;
    th_seg = BL;
    disp_q.delete(); conv_q.delete();
    value = 13'd8191;
    for (int c = 1; c <= 64; c++) begin
      step(tick);
      if (dut.u_conv.bcd_valid === 1'b1 && conv_q.size() > 0) begin
        ev = conv_q.pop_front();
        vectors++;
        if (dut.u_conv.bcd !== to_bcd(ev)) begin
          miscompares++; $display("FAIL max_bcd_c%0d: got %h want %h", c, dut.u_conv.bcd, to_bcd(ev));
        end
      end
      if (tick) begin
        e = disp_q.pop_front();
        vectors++;
        if (anode !== e.anode || seg !== e.seg || seg_nb !== e.seg_nb) begin
          miscompares++;
          $display("FAIL max_slot_c%0d: got %b/%b/%b want %b/%b/%b", c, anode, seg, seg_nb, e.anode, e.seg, e.seg_nb);
        end
        if (m_idx == 2'd3) th_seg = seg;
      end
    end
    vectors++;
    if (dut.bcd_reg !== 16'h8191) begin miscompares++; $display("FAIL max_bcd_reg: got %h want 8191", dut.bcd_reg); end
    vectors++;
    if (th_seg !== 7'b0000000) begin miscompares++; $display("FAIL max_thousands: got %b want 0000000", th_seg); end
  endtask

  task automatic test_blanking();
    bit tick; disp_t e; int v;
    logic [6:0] want_b [4];
    logic [6:0] want_nb [4];
    logic [6:0] cap_b [4];
    logic [6:0] cap_nb [4];
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin
          v = 7;
          want_b  = '{7'b1111000, BL, BL, BL};
          want_nb = '{7'b1111000, 7'b1000000, 7'b1000000, 7'b1000000};
        end
        1: begin
          v = 0;
          want_b  = '{7'b1000000, BL, BL, BL};
          want_nb = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
        end
        default: begin
          v = 1005;
          want_b  = '{7'b0010010, 7'b1000000, 7'b1000000, 7'b1111001};
          want_nb = '{7'b0010010, 7'b1000000, 7'b1000000, 7'b1111001};
        end
      endcase
      disp_q.delete(); conv_q.delete();
      value = 13'(v);
      for (int i = 0; i < 4; i++) begin cap_b[i] = 7'bx; cap_nb[i] = 7'bx; end
      for (int c = 1; c <= 64; c++) begin
        step(tick);
        if (tick) begin
          e = disp_q.pop_front();
          vectors++;
          if (anode !== e.anode || seg !== e.seg || seg_nb !== e.seg_nb) begin
            miscompares++;
            $display("FAIL blank_slot_v%0d_c%0d: got %b/%b/%b want %b/%b/%b", v, c, anode, seg, seg_nb, e.anode, e.seg, e.seg_nb);
          end
          cap_b[m_idx]  = seg;
          cap_nb[m_idx] = seg_nb;
        end
      end
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (cap_b[i] !== want_b[i]) begin
          miscompares++; $display("FAIL blank_on_v%0d_d%0d: got %b want %b", v, i, cap_b[i], want_b[i]);
        end
        vectors++;
        if (cap_nb[i] !== want_nb[i]) begin
          miscompares++; $display("FAIL blank_off_v%0d_d%0d: got %b want %b", v, i, cap_nb[i], want_nb[i]);
        end
      end
    end
  endtask

  task automatic test_mid_change();
    bit tick; int ev; int nvalid; logic [15:0] hand;
    apply_reset(13'd42);
    repeat (3) step(tick);
    value  = 13'd99;
    nvalid = 0;
    for (int c = 4; c <= 35; c++) begin
      step(tick);
      if (dut.u_conv.bcd_valid === 1'b1) begin
        nvalid++;
        if (conv_q.size() > 0) begin
          ev = conv_q.pop_front();
          vectors++;
          if (dut.u_conv.bcd !== to_bcd(ev)) begin
            miscompares++; $display("FAIL mid_model_c%0d: got %h want %h", c, dut.u_conv.bcd, to_bcd(ev));
          end
        end
        if (nvalid <= 2) begin
          hand = (nvalid == 1) ? 16'h0042 : 16'h0099;
          vectors++;
          if (dut.u_conv.bcd !== hand) begin
            miscompares++; $display("FAIL mid_result%0d: got %h want %h", nvalid, dut.u_conv.bcd, hand);
          end
        end
        if (nvalid == 2) begin
          vectors++;
          if (c - 3 > 30) begin miscompares++; $display("FAIL mid_latency: got %0d clocks want <= 30", c - 3); end
        end
      end
    end
    vectors++;
    if (nvalid < 2) begin miscompares++; $display("FAIL mid_count: got %0d results want 2", nvalid); end
  endtask

  task automatic test_scan_order();
    bit tick; logic [0:3] want_an, prev_an; logic [6:0] prev_seg;
    apply_reset(13'd1234);
    prev_an = 4'b1111; prev_seg = BL;
    for (int c = 1; c <= 20; c++) begin
      step(tick);
      if (tick) void'(disp_q.pop_front());
      want_an = (c < 4) ? 4'b1111 : exp_anode(2'((c / 4) % 4));
      vectors++;
      if (anode !== want_an) begin miscompares++; $display("FAIL scan_anode_c%0d: got %b want %b", c, anode, want_an); end
      if (c >= 4) begin
        vectors++;
        if ($countones(~anode) != 1) begin miscompares++; $display("FAIL scan_onehot_c%0d: got %b want one low", c, anode); end
      end
      if (!tick) begin
        vectors++;
        if (anode !== prev_an || seg !== prev_seg) begin
          miscompares++; $display("FAIL scan_hold_c%0d: got %b/%b want %b/%b", c, anode, seg, prev_an, prev_seg);
        end
      end
      prev_an = anode; prev_seg = seg;
    end
  endtask

  task automatic test_reset_mid_op();
    bit tick; logic exp_v;
    apply_reset(13'd1234);
    repeat (22) step(tick);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (anode !== 4'b1111 || anode_nb !== 4'b1111) begin
      miscompares++; $display("FAIL midrst_anode: got %b/%b want 1111", anode, anode_nb);
    end
    vectors++;
    if (seg !== BL || seg_nb !== BL) begin miscompares++; $display("FAIL midrst_seg: got %b/%b want %b", seg, seg_nb, BL); end
    vectors++;
    if (dut.bcd_reg !== 16'h0000) begin miscompares++; $display("FAIL midrst_bcd_reg: got %h want 0000", dut.bcd_reg); end
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step(tick);
      if (tick) void'(disp_q.pop_front());
      if (dut.u_conv.bcd_valid === 1'b1 && conv_q.size() > 0) void'(conv_q.pop_front());
      exp_v = (c == 14);
      vectors++;
      if (dut.u_conv.bcd_valid !== exp_v) begin
        miscompares++; $display("FAIL midrst_valid_c%0d: got %b want %b", c, dut.u_conv.bcd_valid, exp_v);
      end
      if (c <= 4) begin
        vectors++;
        if (anode !== ((c < 4) ? 4'b1111 : 4'b1101)) begin
          miscompares++; $display("FAIL midrst_tick_c%0d: got %b want %b", c, anode, (c < 4) ? 4'b1111 : 4'b1101);
        end
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    value = 13'd0;
    model_reset();
    test_reset();
    test_conversion();
    test_max_value();
    test_blanking();
    test_mid_change();
    test_scan_order();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
